// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_if
// Brief    : E-stage bus between the pipeline and the multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface mdu_if;
  logic [3:0]  MDUctr;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  HiLo;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUout;

  modport master (output MDUctr, A, B, HiLo, input Start, Busy, MDUout);
  modport slave  (input MDUctr, A, B, HiLo, output Start, Busy, MDUout);
endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Fixed-latency mult/div unit holding HI/LO, with mthi/mtlo/mfhi/mflo.
// Revision : 1.0
// ============================================================================
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire   clk,
  input  wire   reset,
  mdu_if.slave  bus
);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mthi  = 4'd5;
  localparam logic [3:0] c_op_mtlo  = 4'd6;
  localparam logic [3:0] c_mult_n   = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_n    = 4'(DIV_CYCLES);

  logic [31:0] r_hi, r_lo, r_ph, r_pl;
  logic [3:0]  r_cnt;
  logic        r_busy, r_div0;

  logic        w_is_mul, w_is_div, w_signed, w_start;
  logic        w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b, w_dvs, w_dvu;
  logic [31:0] w_qs_mag, w_rs_mag, w_qs, w_rs, w_qu, w_ru;
  logic [63:0] w_smul, w_umul, w_res;

  // Op decode
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    case (bus.MDUctr)
      c_op_mult:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      c_op_multu: w_is_mul = 1'b1;
      c_op_div:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      c_op_divu:  w_is_div = 1'b1;
      default:    ;
    endcase
  end

  assign w_start = (w_is_mul | w_is_div) & ~r_busy;

  assign w_smul = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_umul = {32'b0, bus.A} * {32'b0, bus.B};

  // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  assign w_neg_a  = bus.A[31];
  assign w_neg_b  = bus.B[31];
  assign w_mag_a  = w_neg_a ? (~bus.A + 32'd1) : bus.A;
  assign w_mag_b  = w_neg_b ? (~bus.B + 32'd1) : bus.B;
  assign w_dvs    = (bus.B == 32'd0) ? 32'd1 : w_mag_b;
  assign w_dvu    = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign w_qs_mag = w_mag_a / w_dvs;
  assign w_rs_mag = w_mag_a % w_dvs;
  assign w_qs     = (w_neg_a ^ w_neg_b) ? (~w_qs_mag + 32'd1) : w_qs_mag;
  assign w_rs     = w_neg_a ? (~w_rs_mag + 32'd1) : w_rs_mag;
  assign w_qu     = bus.A / w_dvu;
  assign w_ru     = bus.A % w_dvu;

  always_comb begin
    w_res = 64'd0;
    if (w_is_mul)
      w_res = w_signed ? w_smul : w_umul;
    else if (w_is_div)
      w_res = w_signed ? {w_rs, w_qs} : {w_ru, w_qu};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_ph   <= 32'd0;
      r_pl   <= 32'd0;
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
      r_div0 <= 1'b0;
    end else if (w_start) begin
      r_ph   <= w_res[63:32];
      r_pl   <= w_res[31:0];
      r_div0 <= w_is_div & (bus.B == 32'd0);
      r_cnt  <= w_is_mul ? c_mult_n : c_div_n;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        if (!r_div0) begin
          r_hi <= r_ph;
          r_lo <= r_pl;
        end
      end
    end else if (bus.MDUctr == c_op_mthi) begin
      r_hi <= bus.A;
    end else if (bus.MDUctr == c_op_mtlo) begin
      r_lo <= bus.A;
    end
  end

  assign bus.Start = w_start;
  assign bus.Busy  = r_busy;

  always_comb begin
    bus.MDUout = 32'd0;
    case (bus.HiLo)
      2'd1:    bus.MDUout = r_hi;
      2'd2:    bus.MDUout = r_lo;
      default: bus.MDUout = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Brief    : Directed scoreboard bench for mdu (mult/div latency, HI/LO, reset).
// Revision : 1.0
// ============================================================================
module tb_mdu;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] m_hi, m_lo;
  logic [63:0] sb[$];

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, optionally presenting inj_op at busy cycle inj_cyc,
  // then verify Busy length, stale reads during Busy, and the committed HI/LO.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int n,
                       input int inj_cyc, input logic [3:0] inj_op);
    int cnt;
    logic [63:0] exp;
    @(posedge clk); #1;
    bus.MDUctr = op; bus.A = a; bus.B = b; bus.HiLo = 2'd1;
    @(negedge clk);
    check({tag, "_start"}, 32'(bus.Start), 32'd1);
    check({tag, "_busy_pre"}, 32'(bus.Busy), 32'd0);
    sb.push_back({exp_hi, exp_lo});
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus.MDUctr = (i == inj_cyc) ? inj_op : 4'd0;
      bus.A      = (i == inj_cyc) ? 32'hDEADBEEF : a;
      @(negedge clk);
      if (!bus.Busy) break;
      cnt++;
      check({tag, "_start_busy"}, 32'(bus.Start), 32'd0);
      check({tag, "_stale_hi"}, bus.MDUout, m_hi);
    end
    bus.MDUctr = 4'd0;
    check({tag, "_busy_len"}, 32'(cnt), 32'(n));
    check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_hi"}, bus.MDUout, exp[63:32]);
      bus.HiLo = 2'd2; #1;
      check({tag, "_lo"}, bus.MDUout, exp[31:0]);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b0;
    bus.MDUctr = 4'd0; bus.A = 32'd0; bus.B = 32'd0; bus.HiLo = 2'd1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_start", 32'(bus.Start), 32'd0);
    check("rst_hi", bus.MDUout, 32'd0);
    bus.HiLo = 2'd2; #1;
    check("rst_lo", bus.MDUout, 32'd0);

    issue("mult",  4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 0, 4'd0);
    issue("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 3, 4'd3);
    issue("div",   4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0, 4'd0);
    issue("divu",  4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0, 4'd0);
    issue("div0",  4'd3, 32'd55, 32'd0, m_hi, m_lo, 10, 0, 4'd0);
    issue("divov", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0, 4'd0);

    // mthi then mtlo, each visible in the following cycle
    @(posedge clk); #1;
    bus.MDUctr = 4'd5; bus.A = 32'h12345678; bus.HiLo = 2'd1;
    @(negedge clk);
    check("mthi_start", 32'(bus.Start), 32'd0);
    @(posedge clk); #1;
    bus.MDUctr = 4'd6; bus.A = 32'h9ABCDEF0;
    @(negedge clk);
    check("mthi_hi", bus.MDUout, 32'h12345678);
    @(posedge clk); #1;
    bus.MDUctr = 4'd0; bus.HiLo = 2'd2;
    @(negedge clk);
    check("mtlo_lo", bus.MDUout, 32'h9ABCDEF0);
    bus.HiLo = 2'd0; #1;
    check("hilo0", bus.MDUout, 32'd0);
    bus.HiLo = 2'd3; #1;
    check("hilo3", bus.MDUout, 32'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    issue("mult_inj", 4'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5, 2, 4'd6);

    // Reset pulsed at busy cycle 3 of a div aborts it for good
    @(posedge clk); #1;
    bus.MDUctr = 4'd3; bus.A = 32'd100; bus.B = 32'd7; bus.HiLo = 2'd1;
    @(negedge clk);
    check("rdiv_start", 32'(bus.Start), 32'd1);
    @(posedge clk); #1 bus.MDUctr = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rdiv_busy3", 32'(bus.Busy), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rdiv_busy_clr", 32'(bus.Busy), 32'd0);
    check("rdiv_hi_clr", bus.MDUout, 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("rdiv_busy_late", 32'(bus.Busy), 32'd0);
    check("rdiv_hi_late", bus.MDUout, 32'd0);
    bus.HiLo = 2'd2; #1;
    check("rdiv_lo_late", bus.MDUout, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the pipelined MIPS CPU.
- Consumes the 4-bit MDUctr code and the 2-bit HiLo select produced by the controller.
- Performs mult/multu/div/divu with fixed multi-cycle latency, holds the HI/LO registers, and services mthi/mtlo/mfhi/mflo.
- Exports Start/Busy so the hazard unit can stall later MDU instructions.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset: sampled on the rising edge of clk, reset asserted when low.
- MDUctr  input  4  op in E this cycle: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7..15 are treated as none.
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- HiLo  input  2  read select: 1 HI, 2 LO, 0 or 3 drive 0.
- Start  output  1  combinational; high in the cycle a mult/div is accepted.
- Busy  output  1  registered; high while a mult/div is in flight.
- MDUout  output  32  combinational read data for mfhi/mflo.

Behaviour:
- Reset (reset==0 at a clock edge):
  - HI=0, LO=0, Busy=0, counter=0, pending result discarded.
  - Applies mid-operation too: after that edge Busy=0, and no commit ever happens for the aborted op.
- Start:
  - Start = (MDUctr in 1..4) and !Busy.
  - Start is independent of reset and of the HiLo input.
- Accept (edge ending cycle T with Start=1):
  - A and B are captured and the 64-bit result is computed into pending registers PH/PL.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); Busy=1 from cycle T+1.
- Busy cycles:
  - Counter decrements at each edge.
  - At the edge where the counter is 1: HI<=PH, LO<=PL, Busy<=0.
  - Busy is therefore high exactly in cycles T+1..T+N; mfhi/mflo in cycle T+N+1 reads the new value.
- Read during Busy: MDUout returns the old, architecturally committed HI/LO. The hazard unit must stall; the MDU does not forward pending values.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: unsigned 32x32 to 64; same HI/LO split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (A).
  - divu: unsigned; LO=quotient, HI=remainder.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): Busy still runs the full DIV_CYCLES; at completion HI and LO stay unchanged. No exception is raised.
- mthi/mtlo (MDUctr 5 or 6, Busy=0): HI or LO <= A at that edge; Start stays 0. A read in the next cycle sees the new value.
- Ops presented while Busy=1 (codes 1..6): ignored, and state is unaffected. A well-formed pipeline never does this.
- Back-to-back:
  - A new mult/div can be accepted in the first cycle Busy=0, i.e. cycle T+N+1.
  - A mthi in the cycle after completion overrides the just-committed HI.
- Start, when it occurs, lasts exactly one cycle per accepted op. It fires whenever an accepted op code is present in a non-busy cycle.
- MDUout mux: HiLo==1 gives HI; HiLo==2 gives LO; otherwise 0.
- Expected size: about 150-250 lines of RTL (counter, op decode, signed/unsigned mult/div paths, pending regs, commit, read mux).

Test Plan:
- Reset low for 2 cycles, then high; MDUctr=0 -> Busy=0, Start=0; MDUout=0 for HiLo=1 and for HiLo=2.
- mult, A=0xFFFFFFFF, B=2 -> Start=1 for 1 cycle; Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Sampling HiLo=1 during Busy returns old HI (0).
- multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=2 -> LO=3, HI=1.
- div, B=0 -> Busy for 10 cycles, HI/LO unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> next-cycle reads give HI=0x12345678, LO=0x9ABCDEF0.
- mult accepted, then MDUctr=6 presented at Busy cycle 2 -> ignored; commit values are unchanged by it.
- Reset pulsed low at Busy cycle 3 of a div -> Busy=0 after that edge; HI=LO=0; no later commit.
